// File: rtl/tm1638_pkg.sv
// rtl/tm1638_pkg.sv - TM1638 command bytes, frame sizes, FSM states and frame byte lookup
package tm1638_pkg;

    localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0     = 8'hC0;
    localparam logic [7:0] CMD_DISP_ON   = 8'h88;

    localparam logic [4:0] NBYTES_F0 = 5'd1;
    localparam logic [4:0] NBYTES_F1 = 5'd17;
    localparam logic [4:0] NBYTES_F2 = 5'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_FIN
    } state_t;

    // Index of the final byte in a frame
    function automatic logic [4:0] frame_last_idx(input logic [1:0] frame);
        case (frame)
            2'd0:    return NBYTES_F0 - 5'd1;
            2'd1:    return NBYTES_F1 - 5'd1;
            default: return NBYTES_F2 - 5'd1;
        endcase
    endfunction

    // Byte idx of a frame; in F1 idx 0 is the address, idx n>0 is display byte d(n-1)
    function automatic logic [7:0] frame_byte(input logic [1:0] frame,
                                              input logic [4:0] idx,
                                              input logic [7:0] snap,
                                              input logic [2:0] bright);
        logic [3:0] half;
        half = idx[4:1] - 4'd1;
        case (frame)
            2'd0: frame_byte = CMD_DATA_AUTO;
            2'd1: begin
                if (idx == 5'd0)
                    frame_byte = CMD_ADDR0;
                else if (!idx[0])
                    frame_byte = {7'b0, snap[half[2:0]]};
                else
                    frame_byte = 8'h00;
            end
            default: frame_byte = CMD_DISP_ON | {5'b0, bright};
        endcase
    endfunction

endpackage

// File: rtl/tm1638_led_refresh_if.sv
// rtl/tm1638_led_refresh_if.sv - pattern-side request signals and TM1638 pins
interface tm1638_led_refresh_if;
    logic [7:0] led;
    logic       update;
    logic       busy;
    logic       done;
    logic       stb;
    logic       sclk;
    logic       dio_out;
    logic       dio_oe;

    modport master (
        output led, update,
        input  busy, done, stb, sclk, dio_out, dio_oe
    );

    modport slave (
        input  led, update,
        output busy, done, stb, sclk, dio_out, dio_oe
    );
endinterface

// File: rtl/tm1638_byte_tx.sv
// rtl/tm1638_byte_tx.sv - LSB-first byte serializer driving sclk/dio
module tm1638_byte_tx #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       sclk_o,
    output logic       dio_o
);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL_END = CW'(2 * CLK_DIV - 1);

    logic          active_q;
    logic [CW-1:0] phase_q;
    logic [2:0]    bit_q;
    logic [6:0]    sh_q;
    logic          sclk_q;
    logic          dio_q;
    logic          last_cycle;

    // Ready also in the final cycle of a byte so the next byte follows with no gap
    assign last_cycle = active_q && (phase_q == FULL_END) && (bit_q == 3'd7);
    assign ready_o    = !active_q || last_cycle;
    assign sclk_o     = sclk_q;
    assign dio_o      = dio_q;

    // Each bit: sclk low for CLK_DIV cycles (dio updated on the fall), then high for CLK_DIV
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            phase_q  <= '0;
            bit_q    <= 3'd0;
            sh_q     <= 7'd0;
            sclk_q   <= 1'b1;
            dio_q    <= 1'b0;
        end else if (start_i && ready_o) begin
            active_q <= 1'b1;
            phase_q  <= '0;
            bit_q    <= 3'd0;
            sh_q     <= data_i[7:1];
            sclk_q   <= 1'b0;
            dio_q    <= data_i[0];
        end else if (active_q) begin
            if (phase_q == HALF_END)
                sclk_q <= 1'b1;
            if (phase_q == FULL_END) begin
                phase_q <= '0;
                if (bit_q == 3'd7) begin
                    active_q <= 1'b0;
                end else begin
                    bit_q  <= bit_q + 3'd1;
                    sclk_q <= 1'b0;
                    dio_q  <= sh_q[0];
                    sh_q   <= {1'b0, sh_q[6:1]};
                end
            end else begin
                phase_q <= phase_q + CW'(1);
            end
        end
    end
endmodule

// File: rtl/tm1638_led_refresh.sv
// rtl/tm1638_led_refresh.sv - sequences the three TM1638 frames that push an 8-bit LED vector
module tm1638_led_refresh
    import tm1638_pkg::*;
#(
    parameter int          CLK_DIV = 25,
    parameter logic [2:0]  BRIGHT  = 3'd7
) (
    input  logic                   clk,
    input  logic                   rst,
    tm1638_led_refresh_if.slave    bus
);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(2 * CLK_DIV - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    frame_q;
    logic [4:0]    byte_q;
    logic [7:0]    snap_q;
    logic          pend_q;
    logic          busy_q;
    logic          done_q;
    logic          stb_q;
    logic          oe_q;

    logic          req;
    logic          tx_start;
    logic          tx_ready;
    logic          tx_sclk;
    logic          tx_dio;
    logic [4:0]    tx_idx;
    logic [7:0]    tx_data;

    assign req = bus.update || pend_q;

    // Launch the first byte at the end of SETUP, then chain the rest of the frame back-to-back
    always_comb begin
        tx_start = 1'b0;
        tx_idx   = byte_q + 5'd1;
        if (state_q == ST_SETUP && cnt_q == DIV_END) begin
            tx_start = 1'b1;
            tx_idx   = 5'd0;
        end else if (state_q == ST_SHIFT && tx_ready && byte_q != frame_last_idx(frame_q)) begin
            tx_start = 1'b1;
        end
        tx_data = frame_byte(frame_q, tx_idx, snap_q, BRIGHT);
    end

    tm1638_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .start_i (tx_start),
        .data_i  (tx_data),
        .ready_o (tx_ready),
        .sclk_o  (tx_sclk),
        .dio_o   (tx_dio)
    );

    // Frame sequencer: snapshot, STB framing, pending request and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            frame_q <= 2'd0;
            byte_q  <= 5'd0;
            snap_q  <= 8'd0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stb_q   <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q && bus.update)
                pend_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (req) begin
                        snap_q  <= bus.led;
                        pend_q  <= 1'b0;
                        frame_q <= 2'd0;
                        cnt_q   <= '0;
                        stb_q   <= 1'b0;
                        oe_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == DIV_END) begin
                        cnt_q   <= '0;
                        byte_q  <= 5'd0;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (tx_ready) begin
                        if (byte_q == frame_last_idx(frame_q)) begin
                            cnt_q   <= '0;
                            state_q <= ST_HOLD;
                        end else begin
                            byte_q <= byte_q + 5'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == DIV_END) begin
                        cnt_q <= '0;
                        stb_q <= 1'b1;
                        oe_q  <= 1'b0;
                        if (frame_q == 2'd2) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_END) begin
                        cnt_q   <= '0;
                        frame_q <= frame_q + 2'd1;
                        stb_q   <= 1'b0;
                        oe_q    <= 1'b1;
                        state_q <= ST_SETUP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.stb     = stb_q;
    assign bus.dio_oe  = oe_q;
    assign bus.sclk    = tx_sclk;
    assign bus.dio_out = tx_dio;
endmodule

// File: tb/tb_tm1638_led_refresh.sv
// tb/tb_tm1638_led_refresh.sv - self-checking bench for tm1638_led_refresh
module tb_tm1638_led_refresh;
    localparam int         D  = 2;
    localparam logic [2:0] BR = 3'd7;
    localparam int EXP_BUSY = (2 + 16 * 1) * D + 2 * D + (2 + 16 * 17) * D + 2 * D + (2 + 16 * 1) * D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tm1638_led_refresh_if bus();

    tm1638_led_refresh #(.CLK_DIV(D), .BRIGHT(BR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] got_bytes[$];
    logic [7:0] exp_bytes[$];
    int         got_flen[$];
    int         exp_flen[$];

    int         done_cnt  = 0;
    int         bad_phase = 0;
    int         bad_dio   = 0;
    logic       prev_stb  = 1'b1;
    logic       prev_sclk = 1'b1;
    logic       prev_dio  = 1'b0;
    int         run_len   = 0;
    int         nbits     = 0;
    int         frame_n   = 0;
    logic       seen_low  = 1'b0;
    logic [7:0] shreg     = 8'd0;

    // Pin-level decoder: bytes on sclk rising edges while stb is low, plus phase-length checks
    always @(negedge clk) begin
        if (bus.done === 1'b1)
            done_cnt++;
        if (bus.stb === 1'b0) begin
            if (prev_stb !== 1'b0) begin
                nbits    = 0;
                frame_n  = 0;
                seen_low = 1'b0;
                run_len  = 1;
            end else begin
                if (bus.sclk === prev_sclk) begin
                    run_len++;
                end else begin
                    if (prev_sclk === 1'b0) begin
                        if (run_len != D) bad_phase++;
                        seen_low = 1'b1;
                    end else if (seen_low && run_len != D) begin
                        bad_phase++;
                    end
                    run_len = 1;
                    if (bus.sclk === 1'b1) begin
                        shreg = {bus.dio_out, shreg[7:1]};
                        nbits++;
                        if (nbits == 8) begin
                            got_bytes.push_back(shreg);
                            frame_n++;
                            nbits = 0;
                        end
                    end
                end
                if (prev_sclk === 1'b1 && bus.sclk === 1'b1 && bus.dio_out !== prev_dio)
                    bad_dio++;
            end
        end else if (prev_stb === 1'b0) begin
            got_flen.push_back(frame_n);
        end
        prev_stb  = bus.stb;
        prev_sclk = bus.sclk;
        prev_dio  = bus.dio_out;
    end

    // Expected byte stream of one refresh, straight from the TM1638 write sequence
    function automatic void model_refresh(input logic [7:0] l);
        exp_bytes.push_back(8'h40);
        exp_bytes.push_back(8'hC0);
        for (int n = 0; n < 16; n++)
            exp_bytes.push_back((n % 2 == 1) ? {7'b0, l[n / 2]} : 8'h00);
        exp_bytes.push_back(8'h88 | {5'b0, BR});
        exp_flen.push_back(1);
        exp_flen.push_back(17);
        exp_flen.push_back(1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
        check({tag, "_nframes"}, got_flen.size(), exp_flen.size());
        for (int i = 0; i < exp_flen.size() && i < got_flen.size(); i++)
            check($sformatf("%s_frame%0d_len", tag, i), got_flen[i], exp_flen[i]);
        got_bytes.delete();
        exp_bytes.delete();
        got_flen.delete();
        exp_flen.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stb"},     bus.stb,     1);
        check({tag, "_sclk"},    bus.sclk,    1);
        check({tag, "_dio_out"}, bus.dio_out, 0);
        check({tag, "_dio_oe"},  bus.dio_oe,  0);
        check({tag, "_busy"},    bus.busy,    0);
        check({tag, "_done"},    bus.done,    0);
    endtask

    task automatic start_refresh(input logic [7:0] l, input string tag);
        bus.led    = l;
        bus.update = 1'b1;
        model_refresh(l);
        @(negedge clk);
        check({tag, "_busy_start"}, bus.busy, 1);
        check({tag, "_stb_start"},  bus.stb,  0);
    endtask

    // Count busy cycles while applying timed led changes, update pulses or a reset
    task automatic run_busy(input int led_at, input logic [7:0] led_new, input int up1,
                            input int up2, input int rst_at, output int len);
        len = 0;
        while (bus.busy === 1'b1 && len < 4 * EXP_BUSY) begin
            bus.update = (len == up1 || len == up2);
            if (len == led_at) bus.led = led_new;
            if (len == rst_at) begin
                rst = 1'b1;
                break;
            end
            len++;
            @(negedge clk);
        end
    endtask

    task automatic finish_check(input string tag, input int len);
        check({tag, "_busy_len"},  len,      EXP_BUSY);
        check({tag, "_done_pulse"}, bus.done, 1);
        check({tag, "_stb_at_done"}, bus.stb, 1);
        @(negedge clk);
        check({tag, "_done_clear"}, bus.done, 0);
    endtask

    initial begin
        int         len;
        int         d0;
        int         b;
        logic [7:0] r;

        // 1: reset held with update asserted
        rst        = 1'b1;
        bus.update = 1'b1;
        r          = 8'($urandom);
        bus.led    = r;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        rst = 1'b0;
        model_refresh(r);
        @(negedge clk);
        check("reset_release_busy", bus.busy, 1);
        check("reset_release_stb",  bus.stb,  0);
        run_busy(-1, 8'h00, -1, -1, -1, len);
        finish_check("t1", len);
        compare_stream("t1");

        // 2: A5 single refresh with exactly one done pulse
        d0 = done_cnt;
        start_refresh(8'hA5, "t2");
        run_busy(-1, 8'h00, -1, -1, -1, len);
        finish_check("t2", len);
        check("t2_done_count", done_cnt - d0, 1);
        compare_stream("t2");

        // 3: led changes mid-refresh do not reach the frame in flight
        start_refresh(8'h01, "t3");
        run_busy(50, 8'hFF, -1, -1, -1, len);
        finish_check("t3", len);
        compare_stream("t3");

        // 4: two requests while busy collapse into one follow-up refresh with 3C
        d0 = done_cnt;
        r  = 8'($urandom);
        start_refresh(r, "t4a");
        run_busy(50, 8'h3C, 100, 200, -1, len);
        finish_check("t4a", len);
        check("t4_followup_busy", bus.busy, 1);
        model_refresh(8'h3C);
        run_busy(-1, 8'h00, -1, -1, -1, len);
        finish_check("t4b", len);
        b = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.busy === 1'b1) b++;
        end
        check("t4_no_third", b, 0);
        check("t4_done_count", done_cnt - d0, 2);
        compare_stream("t4");

        // Random led vectors with random mid-refresh led churn
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            r = 8'($urandom);
            start_refresh(r, $sformatf("rnd%0d", k));
            run_busy($urandom_range(1, 600), 8'($urandom), -1, -1, -1, len);
            finish_check($sformatf("rnd%0d", k), len);
            compare_stream($sformatf("rnd%0d", k));
        end

        // 5: reset mid-F1 with a pending request queued
        d0 = done_cnt;
        start_refresh(8'($urandom), "t5");
        run_busy(-1, 8'h00, 100, -1, 300, len);
        check("t5_reset_point", len, 300);
        @(negedge clk);
        check_reset_outputs("t5_abort");
        rst = 1'b0;
        b   = 0;
        repeat (700) begin
            @(negedge clk);
            if (bus.busy === 1'b1) b++;
        end
        check("t5_no_followup", b, 0);
        check("t5_no_done", done_cnt - d0, 0);
        @(posedge clk);
        got_bytes.delete();
        exp_bytes.delete();
        got_flen.delete();
        exp_flen.delete();

        // 6: sclk phase lengths and dio stability across every frame sent
        check("t6_phase_len", bad_phase, 0);
        check("t6_dio_stable", bad_dio, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tm1638_led_refresh.md
# tm1638_led_refresh

Serial controller that pushes an 8-bit LED vector from the pattern generators (chase, fill/clear sequences) to the TM1638 board driver. On each refresh request it snapshots `led`, then runs the three-frame TM1638 write sequence: data command, address plus 16 display bytes, and display control. It owns the TM1638 `STB`/`CLK`/`DIO` pins, so pattern blocks never touch the serial protocol.

## Interface
- `CLK_DIV`, default 25: SCLK half-period in `clk` cycles. Must be ≥1; 25 gives 1 MHz SCLK from 50 MHz.
- `BRIGHT`, default 3'd7: brightness field of the display-control command.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `led` in 8: LED vector; bit k drives TM1638 LED k.
- `update` in 1: refresh request, level-sampled every cycle.
- `busy` out 1: refresh in progress.
- `done` out 1: one-cycle pulse when a refresh completes.
- `stb` out 1: TM1638 STB, active low.
- `sclk` out 1: TM1638 CLK, idles high.
- `dio_out` out 1: TM1638 DIO data.
- `dio_oe` out 1: DIO output enable (write-only controller).

## Operation
- Reset values: `stb`=1, `sclk`=1, `dio_out`=0, `dio_oe`=0, `busy`=0, `done`=0. The pending flag and the snapshot are cleared.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP, FIN.
- IDLE: when `update`=1 (or the pending flag is set), latch `led` into the snapshot, clear pending, set frame index 0 and go to SETUP.
- Frames, bytes sent LSB first:
  - F0: 0x40 (write data, auto-increment).
  - F1: 0xC0, then d0..d15. Even dN = 0x00 (7-segment digits blank). d(2k+1) = {7'b0, snapshot[k]}.
  - F2: 0x88 | BRIGHT.
- SETUP: `stb`=0, `dio_oe`=1, `sclk`=1 for CLK_DIV cycles.
- SHIFT, per bit:
  - `sclk`=0 for CLK_DIV cycles. `dio_out` changes only in the cycle `sclk` falls.
  - Then `sclk`=1 for CLK_DIV cycles. The TM1638 samples on the rising edge.
- HOLD: after the last bit of a frame, `stb`=0 and `sclk`=1 for CLK_DIV cycles.
- GAP: `stb`=1, `dio_oe`=0 for 2·CLK_DIV cycles. Used after F0 and after F1 only.
- FIN: after F2 HOLD, return to IDLE with `stb`=1 and pulse `done`.
- `update` during `busy` sets the pending flag. Any number of such requests collapse into exactly one follow-up refresh, which snapshots `led` when it starts.
- `led` changes during `busy` do not affect the frame in flight.
- `rst` mid-frame: abort on that edge. All outputs take reset values on the next cycle and no `done` is generated.

## Timing
- Request sampled at edge 0. From edge 1: `busy`=1 and `stb`=0.
- Stb-low time per frame: (2 + 16·nbytes)·CLK_DIV cycles. nbytes is 1, 17, 1.
- Total `busy` duration: 18·CLK_DIV + 4·CLK_DIV + 274·CLK_DIV + 18·CLK_DIV = 314·CLK_DIV cycles.
- First `busy`=0 cycle: `done`=1, and `stb`=1 already.
- Pending follow-up: starts the cycle after `done`. `busy` may be high again one cycle later.
- Counters:
  - Clock-divider counter width: $clog2(2·CLK_DIV).
  - Bit counter: 3 bits, wraps 7→0 at the byte boundary.
  - Byte counter: 5 bits, 0..16.
  - No arithmetic overflow is possible.

## Structure
- Package `tm1638_pkg` holds:
  - CMD_DATA_AUTO = 8'h40, CMD_ADDR0 = 8'hC0, CMD_DISP_ON = 8'h88.
  - Frame byte counts 1/17/1.
  - The FSM state enum.
- Sub-module `tm1638_byte_tx`: serializes one byte with a start/ready handshake, generates `sclk`/`dio_out`, and is parameterized by CLK_DIV.
- Top level: frame/byte sequencing, snapshot, pending flag, `busy`/`done`.

## Test plan
All scenarios use CLK_DIV=2 and BRIGHT=7, with a bench model decoding bytes on `sclk` rising edges while `stb`=0.
1. Reset: hold `rst` for 3 cycles with `update`=1 -> all outputs at reset values, no activity; after release, a refresh starts on the next edge.
2. `led`=8'hA5, one-cycle `update` -> bytes decoded:
   - F0: 0x40.
   - F1: 0xC0, then 00,01,00,00,00,01,00,00,00,00,00,01,00,00,00,01.
   - F2: 0x8F.
   - `busy` lasts 628 cycles, then a single `done` pulse.
3. Start with `led`=8'h01, change `led` to 8'hFF at cycle 50 -> frame still shows only d1=01; `done` at 628.
4. Two `update` pulses during `busy` with `led`=8'h3C -> exactly one follow-up refresh. Odd bytes of the follow-up: 00,00,01,01,01,01,00,00. Two `done` pulses in total.
5. Assert `rst` at cycle 300, mid-F1 -> next cycle `stb`=1, `sclk`=1, `dio_oe`=0. No `done` and no pending follow-up.
6. Bit timing during F0 -> each `sclk` low and high phase lasts exactly 2 cycles, and `dio_out` is stable while `sclk`=1.
